// File: rtl/obi_icn_arbiter_if.sv
// Bundle of the upstream (NUM_REQ requesters) and downstream OBI signals around obi_icn_arbiter.
// slave = arbiter view, master = requesters/interconnect view.
interface obi_icn_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OBI_AW  = 32,
  parameter int unsigned OBI_DW  = 32,
  parameter int unsigned OBI_IDW = 1
);
  localparam int unsigned BE_W = OBI_DW / 8;

  // Upstream A/R control, bit i = requester i
  logic [NUM_REQ-1:0]         up_req;
  logic [NUM_REQ-1:0]         up_we;
  logic [NUM_REQ-1:0]         up_reqpar;
  logic [NUM_REQ-1:0]         up_rready;
  logic [NUM_REQ-1:0]         up_rreadypar;
  logic [NUM_REQ*OBI_AW-1:0]  up_addr;
  logic [NUM_REQ*OBI_DW-1:0]  up_wdata;
  logic [NUM_REQ*BE_W-1:0]    up_be;
  logic [NUM_REQ*OBI_IDW-1:0] up_aid;
  logic [NUM_REQ-1:0]         up_gnt;
  logic [NUM_REQ-1:0]         up_gntpar;
  logic [NUM_REQ-1:0]         up_rvalid;
  logic [NUM_REQ-1:0]         up_rvalidpar;
  logic [NUM_REQ-1:0]         up_err;
  logic [NUM_REQ*OBI_DW-1:0]  up_rdata;
  logic [NUM_REQ*OBI_IDW-1:0] up_rid;

  // Downstream single OBI initiator port
  logic               obi_req;
  logic               obi_reqpar;
  logic               obi_we;
  logic               obi_rready;
  logic               obi_rreadypar;
  logic [OBI_AW-1:0]  obi_addr;
  logic [OBI_DW-1:0]  obi_wdata;
  logic [BE_W-1:0]    obi_be;
  logic [OBI_IDW-1:0] obi_aid;
  logic               obi_gnt;
  logic               obi_gntpar;
  logic               obi_rvalid;
  logic               obi_rvalidpar;
  logic               obi_err;
  logic [OBI_DW-1:0]  obi_rdata;
  logic [OBI_IDW-1:0] obi_rid;

  modport slave (
    input  up_req, up_we, up_reqpar, up_rready, up_rreadypar,
    input  up_addr, up_wdata, up_be, up_aid,
    output up_gnt, up_gntpar, up_rvalid, up_rvalidpar, up_err, up_rdata, up_rid,
    output obi_req, obi_reqpar, obi_we, obi_rready, obi_rreadypar,
    output obi_addr, obi_wdata, obi_be, obi_aid,
    input  obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_err, obi_rdata, obi_rid
  );

  modport master (
    output up_req, up_we, up_reqpar, up_rready, up_rreadypar,
    output up_addr, up_wdata, up_be, up_aid,
    input  up_gnt, up_gntpar, up_rvalid, up_rvalidpar, up_err, up_rdata, up_rid,
    input  obi_req, obi_reqpar, obi_we, obi_rready, obi_rreadypar,
    input  obi_addr, obi_wdata, obi_be, obi_aid,
    output obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_err, obi_rdata, obi_rid
  );
endinterface

// File: rtl/obi_icn_arbiter.sv
// Round-robin arbiter sharing one OBI initiator port between NUM_REQ requesters,
// one outstanding transaction at a time. Interface parameters must match this module's.
module obi_icn_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OBI_AW  = 32,
  parameter int unsigned OBI_DW  = 32,
  parameter int unsigned OBI_IDW = 1,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_en,
  obi_icn_arbiter_if.slave    bus,
  output logic                arb_busy,
  output logic [IDX_W-1:0]    arb_owner
);
  localparam int unsigned BE_W = OBI_DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_eligible;
  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_cand;
  logic               w_addr_ph;
  logic               w_resp_ph;
  logic               w_rready;
  logic               w_unused;

  assign w_eligible = bus.up_req & req_en;
  assign w_addr_ph  = (r_state == S_ADDR);
  assign w_resp_ph  = (r_state == S_RESP);
  assign w_rready   = w_resp_ph & bus.up_rready[r_owner];

  // First eligible requester scanning r_rr_ptr, r_rr_ptr+1, ... modulo NUM_REQ
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && w_eligible[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Once in ADDR the request is held until granted, whatever req_en/up_req do
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_ADDR;
          w_owner_nxt  = w_winner;
          w_rr_ptr_nxt = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);
        end
      end
      S_ADDR: begin
        if (bus.obi_gnt) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.obi_rvalid && w_rready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Downstream A channel: owner's slices while requesting, zero otherwise
  always_comb begin
    bus.obi_req   = w_addr_ph;
    bus.obi_addr  = '0;
    bus.obi_wdata = '0;
    bus.obi_be    = '0;
    bus.obi_we    = 1'b0;
    bus.obi_aid   = '0;
    if (w_addr_ph) begin
      bus.obi_addr  = bus.up_addr[32'(r_owner) * OBI_AW +: OBI_AW];
      bus.obi_wdata = bus.up_wdata[32'(r_owner) * OBI_DW +: OBI_DW];
      bus.obi_be    = bus.up_be[32'(r_owner) * BE_W +: BE_W];
      bus.obi_we    = bus.up_we[r_owner];
      bus.obi_aid   = bus.up_aid[32'(r_owner) * OBI_IDW +: OBI_IDW];
    end
  end

  assign bus.obi_rready    = w_rready;
  assign bus.obi_reqpar    = ~bus.obi_req;
  assign bus.obi_rreadypar = ~bus.obi_rready;

  // Upstream gnt/R pass-through to the owner only; stray gnt/rvalid are dropped
  always_comb begin
    bus.up_gnt    = '0;
    bus.up_rvalid = '0;
    bus.up_rdata  = '0;
    bus.up_rid    = '0;
    bus.up_err    = '0;
    bus.up_gnt[r_owner]    = w_addr_ph & bus.obi_gnt;
    bus.up_rvalid[r_owner] = w_resp_ph & bus.obi_rvalid;
    if (w_resp_ph && bus.obi_rvalid) begin
      bus.up_rdata[32'(r_owner) * OBI_DW +: OBI_DW]   = bus.obi_rdata;
      bus.up_rid[32'(r_owner) * OBI_IDW +: OBI_IDW]   = bus.obi_rid;
      bus.up_err[r_owner]                             = bus.obi_err;
    end
  end

  assign bus.up_gntpar    = ~bus.up_gnt;
  assign bus.up_rvalidpar = ~bus.up_rvalid;

  assign arb_busy  = (r_state != S_IDLE);
  assign arb_owner = r_owner;

  // Incoming parity is deliberately not checked
  assign w_unused = ^{bus.up_reqpar, bus.up_rreadypar, bus.obi_gntpar, bus.obi_rvalidpar};

endmodule

// File: tb/tb_obi_icn_arbiter.sv
// Directed bench for obi_icn_arbiter with three requesters.
module tb_obi_icn_arbiter;
  localparam int unsigned NR  = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 1;
  localparam int unsigned IW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_en;
  logic          arb_busy;
  logic [IW-1:0] arb_owner;
  int            checks = 0;
  int            errors = 0;
  bit            par_on = 1'b0;

  obi_icn_arbiter_if #(.NUM_REQ(NR), .OBI_AW(AW), .OBI_DW(DW), .OBI_IDW(IDW)) bus ();

  obi_icn_arbiter #(
    .NUM_REQ(NR), .OBI_AW(AW), .OBI_DW(DW), .OBI_IDW(IDW), .IDX_W(IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_en   (req_en),
    .bus      (bus),
    .arb_busy (arb_busy),
    .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  // Output parity must always be the inverse of its signal
  always @(negedge clk) begin
    if (par_on) begin
      checks++;
      if (bus.up_gntpar !== ~bus.up_gnt || bus.up_rvalidpar !== ~bus.up_rvalid ||
          bus.obi_reqpar !== ~bus.obi_req || bus.obi_rreadypar !== ~bus.obi_rready) begin
        errors++;
        $display("FAIL parity t=%0t gnt=%b gntpar=%b rvalid=%b rvalidpar=%b req=%b reqpar=%b rready=%b rreadypar=%b",
                 $time, bus.up_gnt, bus.up_gntpar, bus.up_rvalid, bus.up_rvalidpar,
                 bus.obi_req, bus.obi_reqpar, bus.obi_rready, bus.obi_rreadypar);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_en            = 3'b111;
    bus.up_req        = '0;
    bus.up_we         = '0;
    bus.up_reqpar     = 3'b111;
    bus.up_rready     = 3'b111;
    bus.up_rreadypar  = '0;
    bus.up_addr       = {32'h3000_0020, 32'h2000_0010, 32'h0103_0104};
    bus.up_wdata      = {32'hCCCC_0002, 32'hBBBB_0001, 32'hDEAD_0000};
    bus.up_be         = 12'h3CF;
    bus.up_aid        = 3'b001;
    bus.obi_gnt       = 1'b0;
    bus.obi_gntpar    = 1'b1;
    bus.obi_rvalid    = 1'b0;
    bus.obi_rvalidpar = 1'b1;
    bus.obi_err       = 1'b0;
    bus.obi_rdata     = '0;
    bus.obi_rid       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.obi_req !== 1'b0 || bus.obi_reqpar !== 1'b1 || bus.obi_rreadypar !== 1'b1) begin
      errors++;
      $display("FAIL reset_obi req=%b reqpar=%b rreadypar=%b need 0 1 1", bus.obi_req, bus.obi_reqpar, bus.obi_rreadypar);
    end
    checks++;
    if (bus.up_gntpar !== 3'b111 || bus.up_rvalidpar !== 3'b111) begin
      errors++;
      $display("FAIL reset_uppar gntpar=%b rvalidpar=%b need 111 111", bus.up_gntpar, bus.up_rvalidpar);
    end
    checks++;
    if (arb_busy !== 1'b0 || arb_owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_status busy=%b owner=%0d need 0 0", arb_busy, arb_owner);
    end
    checks++;
    if (bus.obi_addr !== '0 || bus.up_gnt !== '0 || bus.up_rvalid !== '0 || bus.up_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h gnt=%b rvalid=%b rdata=%h need zeros", bus.obi_addr, bus.up_gnt, bus.up_rvalid, bus.up_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.up_req = 3'b001;
    bus.up_we  = 3'b001;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || bus.obi_req !== 1'b0) begin
      errors++;
      $display("FAIL single_c0 busy=%b obi_req=%b need 0 0", arb_busy, bus.obi_req);
    end
    tick();
    bus.obi_gnt = 1'b1;
    #1;
    checks++;
    if (bus.obi_req !== 1'b1 || bus.obi_addr !== 32'h0103_0104 || bus.obi_wdata !== 32'hDEAD_0000 ||
        bus.obi_be !== 4'hF || bus.obi_we !== 1'b1 || bus.obi_aid !== 1'b1) begin
      errors++;
      $display("FAIL single_addr req=%b addr=%h wdata=%h be=%h we=%b aid=%b need 1 01030104 dead0000 f 1 1",
               bus.obi_req, bus.obi_addr, bus.obi_wdata, bus.obi_be, bus.obi_we, bus.obi_aid);
    end
    checks++;
    if (bus.up_gnt !== 3'b001 || arb_owner !== 2'd0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt gnt=%b owner=%0d busy=%b need 001 0 1", bus.up_gnt, arb_owner, arb_busy);
    end
    bus.up_req = '0;
    tick();
    bus.obi_gnt = 1'b0;
    #1;
    checks++;
    if (bus.obi_req !== 1'b0 || bus.obi_addr !== '0 || arb_busy !== 1'b1 || bus.obi_rready !== 1'b1 || bus.up_rvalid !== '0) begin
      errors++;
      $display("FAIL single_c2 req=%b addr=%h busy=%b rready=%b rvalid=%b need 0 0 1 1 000",
               bus.obi_req, bus.obi_addr, arb_busy, bus.obi_rready, bus.up_rvalid);
    end
    tick();
    bus.obi_rvalid = 1'b1;
    bus.obi_rdata  = 32'hA5A5_0001;
    bus.obi_rid    = 1'b1;
    #1;
    checks++;
    if (bus.up_rvalid !== 3'b001 || bus.up_rdata !== {32'h0, 32'h0, 32'hA5A5_0001} ||
        bus.up_rid !== 3'b001 || bus.up_err !== '0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_resp rvalid=%b rdata=%h rid=%b err=%b busy=%b need 001 ..a5a50001 001 000 1",
               bus.up_rvalid, bus.up_rdata, bus.up_rid, bus.up_err, arb_busy);
    end
    tick();
    bus.obi_rvalid = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || bus.up_rvalid !== '0) begin
      errors++;
      $display("FAIL single_done busy=%b rvalid=%b need 0 000", arb_busy, bus.up_rvalid);
    end
  endtask

  task automatic test_fairness();
    logic [IW-1:0] exp;
    logic [NR-1:0] exp_oh;
    do_reset();
    bus.up_req     = 3'b111;
    bus.obi_gnt    = 1'b1;
    bus.obi_rvalid = 1'b1;
    bus.obi_rdata  = 32'h1234_5678;
    for (int t = 0; t < 6; t++) begin
      exp    = IW'(t % 3);
      exp_oh = NR'(1) << exp;
      tick();
      checks++;
      if (arb_owner !== exp || bus.up_gnt !== exp_oh) begin
        errors++;
        $display("FAIL fair_addr t=%0d owner=%0d gnt=%b need %0d %b", t, arb_owner, bus.up_gnt, exp, exp_oh);
      end
      tick();
      checks++;
      if (bus.up_rvalid !== exp_oh) begin
        errors++;
        $display("FAIL fair_resp t=%0d rvalid=%b need %b", t, bus.up_rvalid, exp_oh);
      end
      tick();
      checks++;
      if (arb_busy !== 1'b0 || bus.up_rvalid !== '0) begin
        errors++;
        $display("FAIL fair_idle t=%0d busy=%b rvalid=%b need 0 000", t, arb_busy, bus.up_rvalid);
      end
    end
  endtask

  task automatic test_mask();
    logic [IW-1:0] exp;
    do_reset();
    req_en         = 3'b101;
    bus.up_req     = 3'b111;
    bus.obi_gnt    = 1'b1;
    bus.obi_rvalid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      exp = (t == 1) ? 2'd2 : 2'd0;
      tick();
      checks++;
      if (arb_owner !== exp || bus.up_gnt !== (NR'(1) << exp)) begin
        errors++;
        $display("FAIL mask_owner t=%0d owner=%0d gnt=%b need %0d", t, arb_owner, bus.up_gnt, exp);
      end
      tick();
      tick();
    end
    bus.obi_gnt    = 1'b0;
    bus.obi_rvalid = 1'b0;
    tick();
    req_en     = 3'b011;
    bus.up_req = 3'b000;
    #1;
    checks++;
    if (bus.obi_req !== 1'b1 || arb_owner !== 2'd2 || bus.obi_addr !== 32'h3000_0020 || bus.obi_wdata !== 32'hCCCC_0002) begin
      errors++;
      $display("FAIL mask_addr req=%b owner=%0d addr=%h wdata=%h need 1 2 30000020 cccc0002",
               bus.obi_req, arb_owner, bus.obi_addr, bus.obi_wdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.obi_req !== 1'b1 || arb_owner !== 2'd2 || bus.up_gnt !== '0) begin
        errors++;
        $display("FAIL mask_hold c=%0d req=%b owner=%0d gnt=%b need 1 2 000", c, bus.obi_req, arb_owner, bus.up_gnt);
      end
    end
    tick();
    bus.obi_gnt = 1'b1;
    #1;
    checks++;
    if (bus.up_gnt !== 3'b100) begin
      errors++;
      $display("FAIL mask_gnt gnt=%b need 100", bus.up_gnt);
    end
    tick();
    bus.obi_gnt    = 1'b0;
    bus.obi_rvalid = 1'b1;
    #1;
    checks++;
    if (bus.up_rvalid !== 3'b100) begin
      errors++;
      $display("FAIL mask_resp rvalid=%b need 100", bus.up_rvalid);
    end
    tick();
    bus.obi_rvalid = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL mask_done busy=%b need 0", arb_busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.up_req = 3'b010;
    tick();
    bus.up_req = '0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.obi_req !== 1'b1 || bus.up_gnt !== '0 || arb_owner !== 2'd1) begin
        errors++;
        $display("FAIL bp_wait c=%0d req=%b gnt=%b owner=%0d need 1 000 1", c, bus.obi_req, bus.up_gnt, arb_owner);
      end
      tick();
    end
    bus.obi_gnt = 1'b1;
    #1;
    checks++;
    if (bus.up_gnt !== 3'b010 || bus.up_gntpar !== 3'b101 || bus.obi_addr !== 32'h2000_0010) begin
      errors++;
      $display("FAIL bp_gnt gnt=%b gntpar=%b addr=%h need 010 101 20000010", bus.up_gnt, bus.up_gntpar, bus.obi_addr);
    end
    tick();
    bus.obi_gnt    = 1'b0;
    bus.obi_rvalid = 1'b1;
    bus.obi_err    = 1'b1;
    bus.obi_rdata  = 32'hCAFE_F00D;
    bus.up_rready  = 3'b000;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.obi_rready !== 1'b0 || bus.up_rvalid !== 3'b010 || bus.up_err !== 3'b010 || arb_busy !== 1'b1 ||
          bus.up_rdata !== {32'h0, 32'hCAFE_F00D, 32'h0}) begin
        errors++;
        $display("FAIL bp_stall c=%0d rready=%b rvalid=%b err=%b busy=%b rdata=%h need 0 010 010 1 ..cafef00d..",
                 c, bus.obi_rready, bus.up_rvalid, bus.up_err, arb_busy, bus.up_rdata);
      end
      tick();
    end
    bus.up_rready = 3'b010;
    #1;
    checks++;
    if (bus.obi_rready !== 1'b1 || bus.obi_rreadypar !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rready=%b rreadypar=%b need 1 0", bus.obi_rready, bus.obi_rreadypar);
    end
    tick();
    bus.obi_rvalid = 1'b0;
    bus.obi_err    = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || bus.up_err !== '0) begin
      errors++;
      $display("FAIL bp_done busy=%b err=%b need 0 000", arb_busy, bus.up_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.up_req = 3'b010;
    tick();
    bus.obi_gnt = 1'b1;
    bus.up_req  = '0;
    tick();
    bus.obi_gnt = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b1 || arb_owner !== 2'd1 || bus.obi_rready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre busy=%b owner=%0d rready=%b need 1 1 1", arb_busy, arb_owner, bus.obi_rready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (arb_busy !== 1'b0 || bus.obi_req !== 1'b0 || arb_owner !== 2'd0 || bus.obi_rreadypar !== 1'b1 ||
        bus.up_gntpar !== 3'b111 || bus.up_rvalidpar !== 3'b111) begin
      errors++;
      $display("FAIL rmid_post busy=%b req=%b owner=%0d rreadypar=%b gntpar=%b rvalidpar=%b need 0 0 0 1 111 111",
               arb_busy, bus.obi_req, arb_owner, bus.obi_rreadypar, bus.up_gntpar, bus.up_rvalidpar);
    end
    bus.up_req = 3'b110;
    tick();
    checks++;
    if (arb_owner !== 2'd1 || bus.obi_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_rrptr owner=%0d req=%b need 1 1", arb_owner, bus.obi_req);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    bus.obi_rvalid = 1'b1;
    bus.obi_gnt    = 1'b1;
    bus.obi_err    = 1'b1;
    bus.obi_rdata  = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.up_rvalid !== '0 || bus.up_rdata !== '0 || bus.up_err !== '0 || bus.up_gnt !== '0 || bus.obi_rready !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle rvalid=%b rdata=%h err=%b gnt=%b rready=%b need zeros",
               bus.up_rvalid, bus.up_rdata, bus.up_err, bus.up_gnt, bus.obi_rready);
    end
    tick();
    checks++;
    if (arb_busy !== 1'b0 || bus.up_rvalid !== '0 || bus.up_gnt !== '0) begin
      errors++;
      $display("FAIL spur_next busy=%b rvalid=%b gnt=%b need 0 000 000", arb_busy, bus.up_rvalid, bus.up_gnt);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    par_on = 1'b1;
    test_single();
    test_fairness();
    test_mask();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    tick();
    par_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
